// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory bus types and limits for the system block.
// Holds the word type, RAM handshake state encoding and the RAM latency bound.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    localparam int RAM_MAX_LAT = 15;

    function automatic logic is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ram_lat_ctr.sv
// Wait-state counter for the RAM responder: tracks the live request and flags the ACCESS cycle.
// hit is combinational; a changed address/type restarts the wait with cnt=1.
module ram_lat_ctr
    import cpu_types_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  req,
    input  word_t addr,
    input  logic  wr,
    output logic  hit
);

    localparam logic [3:0] LAT_C = 4'(LAT);

    logic [3:0] cnt;
    word_t      req_addr;
    logic       req_wr;
    logic       req_v;
    logic       new_req;

    always_comb begin
        new_req = !req_v || (addr != req_addr) || (wr != req_wr);
        hit     = new_req ? (LAT == 0) : (cnt == LAT_C);
    end

    // A completed access clears req_v so an identical follow-up request waits again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'd0;
            req_addr <= '0;
            req_wr   <= 1'b0;
            req_v    <= 1'b0;
        end else if (!req || hit) begin
            cnt   <= 4'd0;
            req_v <= 1'b0;
        end else if (new_req) begin
            req_addr <= addr;
            req_wr   <= wr;
            req_v    <= 1'b1;
            cnt      <= 4'd1;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/ram_responder.sv
// RAM-side responder: LAT BUSY cycles then one ACCESS cycle per held request; ERROR on bad requests.
// Optional RAM_PERF_EN adds saturating rd_count/wr_count access counters.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
`ifdef RAM_PERF_EN
    ,
    output word_t     rd_count,
    output word_t     wr_count
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);

    if (LAT < 0 || LAT > RAM_MAX_LAT) begin : g_bad_lat
        $error("ram_responder: LAT out of range 0..RAM_MAX_LAT");
    end
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("ram_responder: DEPTH must be a power of two");
    end

    word_t             mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              present;
    logic              err;
    logic              hit;
    logic              do_rd;
    logic              do_wr;

    always_comb begin
        present = ramREN | ramWEN;
        err     = (ramREN & ramWEN)
                | (ramaddr[1:0] != 2'b00)
                | ((ramaddr >> (ADDR_W + 2)) != '0);
        idx     = ramaddr[ADDR_W+1:2];
    end

    ram_lat_ctr #(
        .LAT (LAT)
    ) u_lat_ctr (
        .clk  (CLK),
        .rst  (RST),
        .req  (present & ~err),
        .addr (ramaddr),
        .wr   (ramWEN),
        .hit  (hit)
    );

    always_comb begin
        if (RST || !present) begin
            ramstate = FREE;
        end else if (err) begin
            ramstate = ERROR;
        end else if (hit) begin
            ramstate = ACCESS;
        end else begin
            ramstate = BUSY;
        end
        do_rd   = (ramstate == ACCESS) && ramREN;
        do_wr   = (ramstate == ACCESS) && ramWEN;
        ramload = do_rd ? mem[idx] : '0;
    end

    // Reset clears the array too, so a write caught mid-wait leaves zeros behind.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[idx] <= ramstore;
        end
    end

`ifdef RAM_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (do_rd && (rd_count != '1)) begin
                rd_count <= rd_count + 32'd1;
            end
            if (do_wr && (wr_count != '1)) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (LAT 0/2/3) share one request stream and are
// compared each cycle against a request-age reference model plus fixed expected sequences.
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int DEPTH = 64;
    localparam int NI    = 3;

    logic      CLK = 1'b0;
    logic      RST;
    logic      ren;
    logic      wen;
    word_t     addr;
    word_t     store;
    ramstate_t st [NI];
    word_t     ld [NI];
`ifdef RAM_PERF_EN
    word_t     rdc [NI];
    word_t     wrc [NI];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    ram_responder #(.DEPTH(DEPTH), .LAT(0)) u_lat0 (
        .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
        .ramstore(store), .ramload(ld[0]), .ramstate(st[0])
`ifdef RAM_PERF_EN
        , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
    );
    ram_responder #(.DEPTH(DEPTH), .LAT(2)) u_lat2 (
        .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
        .ramstore(store), .ramload(ld[1]), .ramstate(st[1])
`ifdef RAM_PERF_EN
        , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
    );
    ram_responder #(.DEPTH(DEPTH), .LAT(3)) u_lat3 (
        .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
        .ramstore(store), .ramload(ld[2]), .ramstate(st[2])
`ifdef RAM_PERF_EN
        , .rd_count(rdc[2]), .wr_count(wrc[2])
`endif
    );

    // Reference model: a held request's age is the number of BUSY cycles already spent on it.
    word_t       mem_m  [NI][DEPTH];
    bit          held   [NI];
    word_t       h_addr [NI];
    bit          h_wr   [NI];
    int          age    [NI];
    int unsigned m_rd   [NI];
    int unsigned m_wr   [NI];

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    function automatic bit bad_req();
        return (ren && wen) || (addr[1:0] != 2'b00) || (addr >= DEPTH * 4);
    endfunction

    function automatic int cur_age(input int i);
        return (held[i] && addr == h_addr[i] && wen == h_wr[i]) ? age[i] : 0;
    endfunction

    function automatic ramstate_t exp_state(input int i);
        if (RST || !(ren || wen)) return FREE;
        if (bad_req()) return ERROR;
        return (cur_age(i) == lat_of(i)) ? ACCESS : BUSY;
    endfunction

    function automatic word_t exp_load(input int i);
        if (exp_state(i) == ACCESS && ren) return mem_m[i][int'(addr >> 2)];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < DEPTH; j++) mem_m[i][j] = 32'h0;
            held[i] = 0; h_addr[i] = 0; h_wr[i] = 0; age[i] = 0;
            m_rd[i] = 0; m_wr[i] = 0;
        end
    endtask

    task automatic model_tick();
        ramstate_t s;
        int        a;
        if (RST) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NI; i++) begin
            s = exp_state(i);
            a = cur_age(i);
            if (s == ACCESS && wen) begin
                mem_m[i][int'(addr >> 2)] = store;
                m_wr[i]++;
            end
            if (s == ACCESS && ren) m_rd[i]++;
            if (s == BUSY) begin
                held[i] = 1; h_addr[i] = addr; h_wr[i] = wen; age[i] = a + 1;
            end else begin
                held[i] = 0; age[i] = 0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic w, input word_t a, input word_t d);
        ren = r; wen = w; addr = a; store = d;
    endtask

    task automatic advance();
        model_tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        model_reset();
        drive(1, 0, 32'h10, 32'h0);
        @(negedge CLK);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (st[i] !== FREE) begin
                n_fail++; $display("FAIL reset_state lat%0d got %0d want %0d", lat_of(i), st[i], FREE);
            end
            n_checks++;
            if (ld[i] !== 32'h0) begin
                n_fail++; $display("FAIL reset_load lat%0d got %h want 0", lat_of(i), ld[i]);
            end
`ifdef RAM_PERF_EN
            n_checks++;
            if (rdc[i] !== 32'h0 || wrc[i] !== 32'h0) begin
                n_fail++; $display("FAIL reset_perf lat%0d got rd=%0d wr=%0d want 0/0", lat_of(i), rdc[i], wrc[i]);
            end
`endif
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(0, 0, 32'h0, 32'h0);
        advance();
    endtask

    task automatic test_lat0_read();
        drive(1, 0, 32'h0, 32'h0);
        @(negedge CLK);
        n_checks++;
        if (st[0] !== ACCESS || ld[0] !== 32'h0) begin
            n_fail++; $display("FAIL lat0_first_cycle got st=%0d ld=%h want st=%0d ld=0", st[0], ld[0], ACCESS);
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (st[i] !== exp_state(i)) begin
                n_fail++; $display("FAIL lat0_model lat%0d got %0d want %0d", lat_of(i), st[i], exp_state(i));
            end
        end
        advance();
        drive(0, 0, 32'h0, 32'h0);
        advance();
    endtask

    task automatic test_lat2_write_read();
        ramstate_t wseq [4] = '{BUSY, BUSY, ACCESS, FREE};
        for (int c = 0; c < 4; c++) begin
            if (c < 3) drive(0, 1, 32'h10, 32'hDEADBEEF);
            else       drive(0, 0, 32'h0, 32'h0);
            @(negedge CLK);
            n_checks++;
            if (st[1] !== wseq[c]) begin
                n_fail++; $display("FAIL lat2_write_seq cyc%0d got %0d want %0d", c, st[1], wseq[c]);
            end
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (st[i] !== exp_state(i)) begin
                    n_fail++; $display("FAIL write_model lat%0d cyc%0d got %0d want %0d", lat_of(i), c, st[i], exp_state(i));
                end
            end
            advance();
        end
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 32'h10, 32'h0);
            @(negedge CLK);
            n_checks++;
            if (st[1] !== ((c == 2) ? ACCESS : BUSY) || ld[1] !== ((c == 2) ? 32'hDEADBEEF : 32'h0)) begin
                n_fail++; $display("FAIL lat2_read_seq cyc%0d got st=%0d ld=%h", c, st[1], ld[1]);
            end
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (ld[i] !== exp_load(i)) begin
                    n_fail++; $display("FAIL read_model lat%0d cyc%0d got %h want %h", lat_of(i), c, ld[i], exp_load(i));
                end
            end
            advance();
        end
        drive(0, 0, 32'h0, 32'h0);
        advance();
    endtask

    task automatic test_errors();
        word_t ea [4] = '{32'h10, 32'h2, DEPTH * 4, 32'h8000_0010};
        logic  er [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic  ew [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 2; c++) begin
                drive(er[p], ew[p], ea[p], 32'h1111_1111);
                @(negedge CLK);
                for (int i = 0; i < NI; i++) begin
                    n_checks++;
                    if (st[i] !== ERROR || ld[i] !== 32'h0) begin
                        n_fail++; $display("FAIL error_pat%0d lat%0d got st=%0d ld=%h want st=%0d ld=0", p, lat_of(i), st[i], ld[i], ERROR);
                    end
                end
                advance();
            end
        end
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 32'h10, 32'h0);
            @(negedge CLK);
            if (c == 2) begin
                n_checks++;
                if (ld[1] !== 32'hDEADBEEF) begin
                    n_fail++; $display("FAIL error_no_side_effect got %h want deadbeef", ld[1]);
                end
            end
            advance();
        end
        drive(0, 0, 32'h0, 32'h0);
        advance();
    endtask

    task automatic test_switch();
        for (int c = 0; c < 5; c++) begin
            if (c < 4) drive(0, 1, 32'h40, 32'hCAFE_0040);
            else       drive(0, 0, 32'h0, 32'h0);
            @(negedge CLK);
            advance();
        end
        for (int c = 0; c < 6; c++) begin
            drive(1, 0, (c < 2) ? 32'h20 : 32'h40, 32'h0);
            @(negedge CLK);
            if (c >= 2) begin
                n_checks++;
                if (st[2] !== ((c == 5) ? ACCESS : BUSY)) begin
                    n_fail++; $display("FAIL switch_state cyc%0d got %0d", c, st[2]);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (ld[2] !== 32'hCAFE_0040) begin
                    n_fail++; $display("FAIL switch_load got %h want cafe0040", ld[2]);
                end
            end
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (st[i] !== exp_state(i) || ld[i] !== exp_load(i)) begin
                    n_fail++; $display("FAIL switch_model lat%0d cyc%0d got st=%0d ld=%h want st=%0d ld=%h",
                                       lat_of(i), c, st[i], ld[i], exp_state(i), exp_load(i));
                end
            end
            advance();
        end
        drive(0, 0, 32'h0, 32'h0);
        advance();
    endtask

    task automatic test_reset_midwrite();
        for (int c = 0; c < 5; c++) begin
            if (c < 4) drive(0, 1, 32'h8, 32'h55);
            else       drive(0, 0, 32'h0, 32'h0);
            advance();
        end
        drive(0, 1, 32'h8, 32'h66);
        advance();
        #2;
        RST = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (st[i] !== FREE || ld[i] !== 32'h0) begin
                n_fail++; $display("FAIL async_reset lat%0d got st=%0d ld=%h want FREE/0", lat_of(i), st[i], ld[i]);
            end
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        drive(0, 0, 32'h0, 32'h0);
        advance();
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 32'h8, 32'h0);
            @(negedge CLK);
            if (c == 2) begin
                n_checks++;
                if (st[1] !== ACCESS || ld[1] !== 32'h0) begin
                    n_fail++; $display("FAIL reset_dropped_write got st=%0d ld=%h want ACCESS/0", st[1], ld[1]);
                end
            end
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (st[i] !== exp_state(i) || ld[i] !== exp_load(i)) begin
                    n_fail++; $display("FAIL post_reset_model lat%0d cyc%0d got st=%0d ld=%h", lat_of(i), c, st[i], ld[i]);
                end
            end
            advance();
        end
        drive(0, 0, 32'h0, 32'h0);
        advance();
    endtask

    task automatic test_random();
        int    left = 0;
        int    k;
        logic  r = 0, w = 0;
        word_t a = 0, d = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (left == 0) begin
                k = $urandom_range(0, 9);
                r = (k >= 2 && k <= 5) || k == 9;
                w = (k >= 6);
                a = $urandom_range(0, 7) * 4;
                if (k == 9 && $urandom_range(0, 1) == 1) begin
                    w = 0;
                    a = a + $urandom_range(1, 3);
                end
                d = $urandom;
                left = $urandom_range(1, 6);
            end
            drive(r, w, a, d);
            @(negedge CLK);
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (st[i] !== exp_state(i) || ld[i] !== exp_load(i)) begin
                    n_fail++; $display("FAIL random lat%0d cyc%0d got st=%0d ld=%h want st=%0d ld=%h",
                                       lat_of(i), cyc, st[i], ld[i], exp_state(i), exp_load(i));
                end
            end
            advance();
            left--;
        end
        drive(0, 0, 32'h0, 32'h0);
        advance();
    endtask

`ifdef RAM_PERF_EN
    task automatic hold(input logic r, input logic w, input word_t a, input int n);
        for (int c = 0; c < n; c++) begin
            drive(r, w, a, 32'h1234_0000 + a);
            advance();
        end
        drive(0, 0, 32'h0, 32'h0);
        advance();
    endtask

    task automatic test_perf();
        RST = 1'b1;
        #2;
        RST = 1'b0;
        model_reset();
        hold(1, 0, 32'h10, 3);
        hold(1, 0, 32'h14, 3);
        hold(1, 0, 32'h18, 3);
        hold(0, 1, 32'h10, 3);
        hold(0, 1, 32'h1C, 3);
        hold(1, 1, 32'h10, 2);
        hold(1, 0, 32'h20, 1);
        @(negedge CLK);
        n_checks++;
        if (rdc[1] !== 32'd3 || wrc[1] !== 32'd2) begin
            n_fail++; $display("FAIL perf_lat2 got rd=%0d wr=%0d want 3/2", rdc[1], wrc[1]);
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (rdc[i] !== m_rd[i] || wrc[i] !== m_wr[i]) begin
                n_fail++; $display("FAIL perf_model lat%0d got rd=%0d wr=%0d want %0d/%0d",
                                   lat_of(i), rdc[i], wrc[i], m_rd[i], m_wr[i]);
            end
        end
        advance();
    endtask
`endif

    initial begin
        test_reset();
        test_lat0_read();
        test_lat2_write_read();
        test_errors();
        test_switch();
        test_reset_midwrite();
        test_random();
`ifdef RAM_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
